if_id_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline: owns the program counter, the PC+4 incrementer, branch/jump redirect, and the IF/ID pipeline register. It sits directly upstream of the hazard detection unit. It consumes that unit's `PC_Write` and `IF_ID_write` stall controls and the redirect requests resolved in ID. It feeds `IF_ID_instr` / `IF_ID_PC4` to decode, and also keeps saturating stall/flush event counters for performance inspection.

---
 rtl/if_id_stage.sv | 127 ++++++++++++
 tb/tb_if_id_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// if_id_stage
//   Instruction-fetch stage of the five-stage MIPS pipeline. It holds the
//   program counter and the PC+4 incrementer, and it applies branch and jump
//   redirects resolved in ID. It also owns the IF/ID pipeline register and
//   two saturating event counters used for performance inspection.
//
// Parameters
//   RESET_PC : PC value loaded on reset.
//   CNT_W    : width of each event counter (>= 2).
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   PC_Write       1 = PC may advance, 0 = hold PC (load-use stall)
//   IF_ID_write    1 = IF/ID register may load, 0 = hold contents
//   branch_taken   taken branch resolved in ID this cycle
//   branch_target  branch destination address
//   jump           jump in ID this cycle
//   jump_target    jump destination address
//   instr_in       instruction memory read data for address PC
//   PC             current fetch address (registered)
//   IF_ID_instr    registered instruction to decode
//   IF_ID_PC4      registered PC+4 of that instruction
//   IF_ID_valid    1 = IF_ID_instr is a real instruction, 0 = bubble
//   stall_cnt      cycles where IF/ID held without a redirect (saturating)
//   flush_cnt      redirects taken (saturating)
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PC_Write,
  input  logic             IF_ID_write,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  input  logic [31:0]      instr_in,
  output logic [31:0]      PC,
  output logic [31:0]      IF_ID_instr,
  output logic [31:0]      IF_ID_PC4,
  output logic             IF_ID_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [31:0]      NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             redirect;
  logic [31:0]      pc_plus4;
  logic [31:0]      pc_next;
  logic [31:0]      instr_next;
  logic [31:0]      pc4_next;
  logic             valid_next;
  logic             stall_evt;
  logic             flush_evt;
  logic [CNT_W-1:0] stall_cnt_next;
  logic [CNT_W-1:0] flush_cnt_next;

  assign redirect = branch_taken | jump;
  assign pc_plus4 = PC + 32'd4;  // 32-bit modulo, FFFF_FFFC wraps to 0

  // Next PC: branch outranks jump; a redirect outranks a PC stall.
  always_comb begin
    pc_next = pc_plus4;
    if (branch_taken) begin
      pc_next = branch_target;
    end else if (jump) begin
      pc_next = jump_target;
    end else if (!PC_Write) begin
      pc_next = PC;
    end
  end

  // IF/ID next state: a redirect flushes the wrong-path fetch even when
  // the hazard unit is asking IF/ID to hold.
  always_comb begin
    instr_next = instr_in;
    pc4_next   = pc_plus4;
    valid_next = 1'b1;
    if (redirect) begin
      instr_next = NOP_INSTR;
      pc4_next   = '0;
      valid_next = 1'b0;
    end else if (!IF_ID_write) begin
      instr_next = IF_ID_instr;
      pc4_next   = IF_ID_PC4;
      valid_next = IF_ID_valid;
    end
  end

  // A stall cycle is only counted when it is not masked by a redirect.
  assign stall_evt = !redirect && !IF_ID_write;
  assign flush_evt = redirect;

  always_comb begin
    stall_cnt_next = stall_cnt;
    flush_cnt_next = flush_cnt;
    if (stall_evt && (stall_cnt != '1)) begin
      stall_cnt_next = stall_cnt + CNT_ONE;
    end
    if (flush_evt && (flush_cnt != '1)) begin
      flush_cnt_next = flush_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      PC          <= RESET_PC;
      IF_ID_instr <= '0;
      IF_ID_PC4   <= '0;
      IF_ID_valid <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      PC          <= pc_next;
      IF_ID_instr <= instr_next;
      IF_ID_PC4   <= pc4_next;
      IF_ID_valid <= valid_next;
      stall_cnt   <= stall_cnt_next;
      flush_cnt   <= flush_cnt_next;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        PC_Write = 1'b1;
  logic        IF_ID_write = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] instr_in;

  logic [31:0] PC, IF_ID_instr, IF_ID_PC4;
  logic        IF_ID_valid;
  logic [15:0] stall_cnt, flush_cnt;

  logic [31:0] s_PC, s_IF_ID_instr, s_IF_ID_PC4;
  logic        s_IF_ID_valid;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  if_id_stage #(.RESET_PC(32'h0000_0000), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .PC_Write(PC_Write), .IF_ID_write(IF_ID_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .instr_in(instr_in),
    .PC(PC), .IF_ID_instr(IF_ID_instr), .IF_ID_PC4(IF_ID_PC4),
    .IF_ID_valid(IF_ID_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  if_id_stage #(.RESET_PC(32'h0000_0000), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .PC_Write(PC_Write), .IF_ID_write(IF_ID_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .instr_in(instr_in),
    .PC(s_PC), .IF_ID_instr(s_IF_ID_instr), .IF_ID_PC4(s_IF_ID_PC4),
    .IF_ID_valid(s_IF_ID_valid), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // Instruction memory model: low words per test plan, elsewhere the
  // address tagged with C in the top nibble.
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'd0:   imem = 32'h11;
      32'd4:   imem = 32'h22;
      32'd8:   imem = 32'h33;
      32'd12:  imem = 32'h44;
      default: imem = 32'hC000_0000 | a;
    endcase
  endfunction

  always_comb instr_in = imem(PC);

  typedef struct {
    int unsigned idx;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] stall;
    logic [15:0] flush;
    logic [3:0]  s_stall;
  } exp_t;

  exp_t sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned vec_idx = 0;

  task automatic chk(input int unsigned idx, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL v%0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents new registered state, compare it
  // against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.idx, "PC",          PC,                    e.pc);
      chk(e.idx, "IF_ID_instr", IF_ID_instr,           e.instr);
      chk(e.idx, "IF_ID_PC4",   IF_ID_PC4,             e.pc4);
      chk(e.idx, "IF_ID_valid", {31'd0, IF_ID_valid},  {31'd0, e.valid});
      chk(e.idx, "stall_cnt",   {16'd0, stall_cnt},    {16'd0, e.stall});
      chk(e.idx, "flush_cnt",   {16'd0, flush_cnt},    {16'd0, e.flush});
      chk(e.idx, "small_PC",    s_PC,                  e.pc);
      chk(e.idx, "small_stall", {28'd0, s_stall_cnt},  {28'd0, e.s_stall});
      chk(e.idx, "small_flush", {28'd0, s_flush_cnt},  {28'd0, e.flush[3:0]});
    end
  end

  // Drive one cycle of inputs and queue the state expected after the edge.
  task automatic vec(input logic r, input logic pcw, input logic ifw,
                     input logic bt, input logic [31:0] btgt,
                     input logic j, input logic [31:0] jtgt,
                     input logic [31:0] e_pc, input logic [31:0] e_instr,
                     input logic [31:0] e_pc4, input logic e_valid,
                     input logic [15:0] e_stall, input logic [15:0] e_flush,
                     input logic [3:0] e_s_stall);
    exp_t e;
    @(negedge clk);
    rst = r; PC_Write = pcw; IF_ID_write = ifw;
    branch_taken = bt; branch_target = btgt;
    jump = j; jump_target = jtgt;
    e.idx = vec_idx; e.pc = e_pc; e.instr = e_instr; e.pc4 = e_pc4;
    e.valid = e_valid; e.stall = e_stall; e.flush = e_flush;
    e.s_stall = e_s_stall;
    sb.push_back(e);
    vec_idx++;
  endtask

  initial begin
    //   rst pcw ifw bt btgt        j  jtgt          PC            instr         PC4           v  stl fl  sstl
    vec(1, 1, 1, 0, 32'h0,       0, 32'h0,       32'h0,        32'h0,        32'h0,        0, 0,  0,  0);
    vec(0, 1, 1, 0, 32'h0,       0, 32'h0,       32'h4,        32'h11,       32'h4,        1, 0,  0,  0);
    vec(0, 1, 1, 0, 32'h0,       0, 32'h0,       32'h8,        32'h22,       32'h8,        1, 0,  0,  0);
    vec(0, 1, 1, 0, 32'h0,       0, 32'h0,       32'hC,        32'h33,       32'hC,        1, 0,  0,  0);
    vec(0, 1, 1, 0, 32'h0,       0, 32'h0,       32'h10,       32'h44,       32'h10,       1, 0,  0,  0);
    // re-reset, then stall at PC=8
    vec(1, 1, 1, 0, 32'h0,       0, 32'h0,       32'h0,        32'h0,        32'h0,        0, 0,  0,  0);
    vec(0, 1, 1, 0, 32'h0,       0, 32'h0,       32'h4,        32'h11,       32'h4,        1, 0,  0,  0);
    vec(0, 1, 1, 0, 32'h0,       0, 32'h0,       32'h8,        32'h22,       32'h8,        1, 0,  0,  0);
    vec(0, 0, 0, 0, 32'h0,       0, 32'h0,       32'h8,        32'h22,       32'h8,        1, 1,  0,  1);
    vec(0, 0, 0, 0, 32'h0,       0, 32'h0,       32'h8,        32'h22,       32'h8,        1, 2,  0,  2);
    vec(0, 1, 1, 0, 32'h0,       0, 32'h0,       32'hC,        32'h33,       32'hC,        1, 2,  0,  2);
    // branch during stall: flush wins, stall not counted
    vec(0, 0, 0, 1, 32'h40,      0, 32'h0,       32'h40,       32'h0,        32'h0,        0, 2,  1,  2);
    vec(0, 1, 1, 0, 32'h0,       0, 32'h0,       32'h44,       32'hC000_0040, 32'h44,      1, 2,  1,  2);
    // branch and jump together: branch target wins
    vec(0, 1, 1, 1, 32'h80,      1, 32'hC0,      32'h80,       32'h0,        32'h0,        0, 2,  2,  2);
    // back-to-back redirect
    vec(0, 1, 1, 0, 32'h0,       1, 32'hC0,      32'hC0,       32'h0,        32'h0,        0, 2,  3,  2);
    vec(0, 1, 1, 0, 32'h0,       0, 32'h0,       32'hC4,       32'hC000_00C0, 32'hC4,      1, 2,  3,  2);
    // PC wrap
    vec(0, 1, 1, 0, 32'h0,       1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,      32'h0,        0, 2,  4,  2);
    vec(0, 1, 1, 0, 32'h0,       0, 32'h0,       32'h0,        32'hFFFF_FFFC, 32'h0,       1, 2,  4,  2);
    // independent controls: PC advances while IF/ID holds, then the reverse
    vec(0, 1, 0, 0, 32'h0,       0, 32'h0,       32'h4,        32'hFFFF_FFFC, 32'h0,       1, 3,  4,  3);
    vec(0, 0, 1, 0, 32'h0,       0, 32'h0,       32'h4,        32'h22,       32'h8,        1, 3,  4,  3);
    // 20 stall cycles: narrow counter saturates at 15
    for (int k = 1; k <= 20; k++) begin
      vec(0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h4, 32'h22, 32'h8, 1,
          16'(3 + k), 4, ((3 + k) > 15) ? 4'd15 : 4'(3 + k));
    end
    // reset during stall and jump
    vec(1, 0, 0, 0, 32'h0,       1, 32'h200,     32'h0,        32'h0,        32'h0,        0, 0,  0,  0);
    vec(0, 1, 1, 0, 32'h0,       0, 32'h0,       32'h4,        32'h11,       32'h4,        1, 0,  0,  0);

    // allow the monitor to drain, bounded
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
